// File: rtl/conv_encoder_framer_pkg.sv
// Shared constants and state encoding for the K=7, rate-1/2 convolutional encoder/framer.
package conv_pkg;

    localparam int K          = 7;
    localparam int MEM        = K - 1;
    localparam logic [K-1:0] G0 = 7'b1011011;
    localparam logic [K-1:0] G1 = 7'b1111001;
    localparam int INFO_BITS  = 58;
    localparam int CODED_BITS = 2 * (INFO_BITS + K - 1);
    localparam int INFO_CNT_W = $clog2(INFO_BITS + 1);
    localparam int TAIL_CNT_W = $clog2(K);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        TAIL = 2'd2
    } state_e;

    // The MSB of taps is the current input; lower bits are the delay line.
    function automatic logic parity(input logic [K-1:0] taps, input logic [K-1:0] g);
        return ^(taps & g);
    endfunction

endpackage

// File: rtl/conv_encoder_framer_if.sv
// Serial upstream handshake plus coded-bit output towards the block interleaver.
interface conv_encoder_framer_if;

    logic in_bit;
    logic in_valid;
    logic in_ready;
    logic out_bit;
    logic load_en;
    logic frame_done;

    modport master (
        output in_bit,
        output in_valid,
        input  in_ready,
        input  out_bit,
        input  load_en,
        input  frame_done
    );

    modport slave (
        input  in_bit,
        input  in_valid,
        output in_ready,
        output out_bit,
        output load_en,
        output frame_done
    );

endinterface

// File: rtl/conv_encoder_framer_core.sv
// Six-bit delay line and the two generator parities; a/b reflect din combined with the current delay line.
module conv_core
    import conv_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic shift_en,
    input  logic din,
    output logic a,
    output logic b
);

    logic [MEM-1:0] sr_q;
    logic [MEM-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (shift_en) begin
            sr_d = {din, sr_q[MEM-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign a = parity({din, sr_q}, G0);
    assign b = parity({din, sr_q}, G1);

endmodule

// File: rtl/conv_encoder_framer.sv
// Frames 58 info bits plus a 6-bit zero tail into 128 coded bits, emitted A then B, one per cycle.
module conv_encoder_framer
    import conv_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    conv_encoder_framer_if.slave   bus
);

    state_e                  state_q, state_d;
    logic                    ph_q, ph_d;
    logic [INFO_CNT_W-1:0]   info_cnt_q, info_cnt_d;
    logic [TAIL_CNT_W-1:0]   tail_cnt_q, tail_cnt_d;
    logic                    out_bit_q, out_bit_d;
    logic                    load_en_q, load_en_d;
    logic                    frame_done_q, frame_done_d;
    logic                    b_hold_q, b_hold_d;

    logic in_ready;
    logic accept;
    logic shift_en;
    logic din;
    logic core_a;
    logic core_b;

    assign in_ready = !rst && (state_q == IDLE || state_q == DATA) && !ph_q;
    assign accept   = bus.in_valid && in_ready;

    conv_core u_core (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_en),
        .din      (din),
        .a        (core_a),
        .b        (core_b)
    );

    // Phase 1 always replays the held B; phase 0 either flushes a tail zero or takes an accepted bit.
    always_comb begin
        state_d      = state_q;
        ph_d         = ph_q;
        info_cnt_d   = info_cnt_q;
        tail_cnt_d   = tail_cnt_q;
        out_bit_d    = out_bit_q;
        load_en_d    = 1'b0;
        frame_done_d = 1'b0;
        b_hold_d     = b_hold_q;
        shift_en     = 1'b0;
        din          = bus.in_bit;

        if (ph_q) begin
            out_bit_d = b_hold_q;
            load_en_d = 1'b1;
            ph_d      = 1'b0;
            if (state_q == DATA && info_cnt_q == INFO_CNT_W'(INFO_BITS)) begin
                state_d = TAIL;
            end else if (state_q == TAIL && tail_cnt_q == TAIL_CNT_W'(MEM)) begin
                frame_done_d = 1'b1;
                state_d      = IDLE;
                info_cnt_d   = '0;
                tail_cnt_d   = '0;
            end
        end else if (state_q == TAIL) begin
            din        = 1'b0;
            shift_en   = 1'b1;
            out_bit_d  = core_a;
            b_hold_d   = core_b;
            load_en_d  = 1'b1;
            ph_d       = 1'b1;
            tail_cnt_d = tail_cnt_q + TAIL_CNT_W'(1);
        end else if (accept) begin
            shift_en   = 1'b1;
            out_bit_d  = core_a;
            b_hold_d   = core_b;
            load_en_d  = 1'b1;
            ph_d       = 1'b1;
            info_cnt_d = info_cnt_q + INFO_CNT_W'(1);
            if (state_q == IDLE) begin
                state_d = DATA;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ph_q         <= 1'b0;
            info_cnt_q   <= '0;
            tail_cnt_q   <= '0;
            out_bit_q    <= 1'b0;
            load_en_q    <= 1'b0;
            frame_done_q <= 1'b0;
            b_hold_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            ph_q         <= ph_d;
            info_cnt_q   <= info_cnt_d;
            tail_cnt_q   <= tail_cnt_d;
            out_bit_q    <= out_bit_d;
            load_en_q    <= load_en_d;
            frame_done_q <= frame_done_d;
            b_hold_q     <= b_hold_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_bit    = out_bit_q;
    assign bus.load_en    = load_en_q;
    assign bus.frame_done = frame_done_q;

endmodule
